mem_dp_bytelane: RTL

Dual-port, byte-lane RV32 memory for the single-cycle and upcoming multi-cycle CPU datapaths. It replaces the separate combinational instruction and data memories. Port I is a read-only word fetch port. Port D is a load/store port with full RV32I sub-word access (lb/lh/lw/lbu/lhu/sb/sh/sw), alignment checking and a registered one-cycle response. Storage is four byte arrays `b0`..`b3` (lane 0 = bits 7:0), indexed by word, so benches can preload programs hierarchically.

---
 rtl/mem_dp_bytelane.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mem_dp_bytelane.sv
// Dual-port byte-lane RV32 memory: read-only word fetch port I and a load/store port D with sub-word access.
// Optional address bounds checking is enabled by defining MEM_BOUNDS_CHECK_EN.
module mem_dp_bytelane #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  output logic              if_fault,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_funct3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_fault
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [7:0] b0 [DEPTH_WORDS];
  logic [7:0] b1 [DEPTH_WORDS];
  logic [7:0] b2 [DEPTH_WORDS];
  logic [7:0] b3 [DEPTH_WORDS];

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] d_idx;
  logic [1:0]       d_off;
  logic [31:0]      if_word;
  logic [31:0]      d_word;
  logic             if_oob;
  logic             d_oob;
  logic             if_fault_c;
  logic             d_illegal;
  logic             d_misal;
  logic             d_fault_c;
  logic             d_wr;
  logic [3:0]       d_be;
  logic [31:0]      d_lanes;

  assign if_idx  = if_addr[IDX_W+1:2];
  assign d_idx   = d_addr[IDX_W+1:2];
  assign d_off   = d_addr[1:0];
  assign if_word = {b3[if_idx], b2[if_idx], b1[if_idx], b0[if_idx]};
  assign d_word  = {b3[d_idx], b2[d_idx], b1[d_idx], b0[d_idx]};

`ifdef MEM_BOUNDS_CHECK_EN
  localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W+1)'(DEPTH_WORDS) << 2;
  assign if_oob = ({1'b0, if_addr} >= MEM_BYTES);
  assign d_oob  = ({1'b0, d_addr} >= MEM_BYTES);
`else
  // Upper address bits only matter for bounds checking; without it the index wraps.
  logic unused_hi;
  assign unused_hi = ^{if_addr[ADDR_W-1:IDX_W+2], d_addr[ADDR_W-1:IDX_W+2]};
  assign if_oob = 1'b0;
  assign d_oob  = 1'b0;
`endif

  // Byte enables for a store of the given size at the given byte offset.
  function automatic logic [3:0] lane_en(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'b00:   return {4{wdata[7:0]}};
      2'b01:   return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  // Shift the addressed byte/halfword to bit 0 and extend according to funct3[2].
  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] word);
    logic [31:0]        sh;
    logic signed [31:0] sx;
    sh = word >> {off, 3'b000};
    case (f3[1:0])
      2'b00: begin
        sx = 32'(signed'(sh[7:0]));
        return f3[2] ? {24'd0, sh[7:0]} : sx;
      end
      2'b01: begin
        sx = 32'(signed'(sh[15:0]));
        return f3[2] ? {16'd0, sh[15:0]} : sx;
      end
      default: return word;
    endcase
  endfunction

  always_comb begin
    d_illegal = 1'b0;
    d_misal   = 1'b0;
    if (d_we)
      d_illegal = d_funct3[2] | (d_funct3[1:0] == 2'b11);
    else
      d_illegal = (d_funct3[1:0] == 2'b11) | (d_funct3[2] & d_funct3[1]);
    case (d_funct3[1:0])
      2'b01:   d_misal = d_off[0];
      2'b10:   d_misal = |d_off;
      default: d_misal = 1'b0;
    endcase
  end

  assign if_fault_c = (|if_addr[1:0]) | if_oob;
  assign d_fault_c  = d_illegal | d_misal | d_oob;
  assign d_be       = lane_en(d_funct3[1:0], d_off);
  assign d_lanes    = lane_data(d_funct3[1:0], d_wdata);
  // A request coinciding with reset is dropped, so writes are gated by rst as well.
  assign d_wr       = d_req & d_we & ~d_fault_c & ~rst;

  always_ff @(posedge clk) begin
    if (d_wr) begin
      if (d_be[0]) b0[d_idx] <= d_lanes[7:0];
      if (d_be[1]) b1[d_idx] <= d_lanes[15:8];
      if (d_be[2]) b2[d_idx] <= d_lanes[23:16];
      if (d_be[3]) b3[d_idx] <= d_lanes[31:24];
    end
  end

  // Response stage: sampled at the request edge; fetch sees pre-store contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rvalid <= 1'b0;
      if_rdata  <= 32'd0;
      if_fault  <= 1'b0;
      d_rvalid  <= 1'b0;
      d_rdata   <= 32'd0;
      d_fault   <= 1'b0;
    end else begin
      if_rvalid <= if_req;
      d_rvalid  <= d_req;
      if (if_req) begin
        if_fault <= if_fault_c;
        if_rdata <= if_fault_c ? 32'd0 : if_word;
      end
      if (d_req) begin
        d_fault <= d_fault_c;
        d_rdata <= (d_fault_c || d_we) ? 32'd0 : load_ext(d_funct3, d_off, d_word);
      end
    end
  end

endmodule
